// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer for a single-port register file: reads ra/rb, runs the ALU,
// writes rd back, and keeps registered result/zero/carry flags.
`timescale 1ns/1ps
module regfile_sequencer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 3,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [ADDR_W-1:0] req_ra,
    input  logic [ADDR_W-1:0] req_rb,
    input  logic [DATA_W-1:0] req_imm,
    output logic [ADDR_W-1:0] rf_address,
    output logic              rf_load,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              rf_reset_all,
    input  logic [DATA_W-1:0] rf_q_out,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_carry
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDI = 3'b101;
    localparam logic [OP_W-1:0] OP_MOV = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_A,
        ST_READ_B,
        ST_WRITE,
        ST_CLEAR
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W:0]   alu;

    // ALU with the carry/borrow in the extra top bit
    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = {1'b0, opa} + {1'b0, opb};
            OP_SUB:  alu = {1'b0, opa} - {1'b0, opb};
            OP_AND:  alu = {1'b0, opa & opb};
            OP_OR:   alu = {1'b0, opa | opb};
            OP_XOR:  alu = {1'b0, opa ^ opb};
            OP_LDI:  alu = {1'b0, imm};
            OP_MOV:  alu = {1'b0, opa};
            default: alu = '0;
        endcase
    end

    // Sequencer state, latched request fields, operands and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            op         <= '0;
            rd         <= '0;
            ra         <= '0;
            rb         <= '0;
            imm        <= '0;
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op  <= req_op;
                        rd  <= req_rd;
                        ra  <= req_ra;
                        rb  <= req_rb;
                        imm <= req_imm;
                        case (req_op)
                            OP_LDI:  state <= ST_WRITE;
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV:
                                     state <= ST_READ_A;
                            default: state <= ST_CLEAR;
                        endcase
                    end
                end
                ST_READ_A: begin
                    opa   <= rf_q_out;
                    state <= (op == OP_MOV) ? ST_WRITE : ST_READ_B;
                end
                ST_READ_B: begin
                    opb   <= rf_q_out;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    result     <= alu[DATA_W-1:0];
                    flag_zero  <= (alu[DATA_W-1:0] == '0);
                    flag_carry <= alu[DATA_W];
                    state      <= ST_IDLE;
                end
                ST_CLEAR: begin
                    result     <= '0;
                    flag_zero  <= 1'b1;
                    flag_carry <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register-file strobes decoded from state; reset masks them in the same cycle
    always_comb begin
        req_ready    = (state == ST_IDLE) && !reset;
        rf_address   = '0;
        rf_load      = 1'b0;
        rf_d_in      = '0;
        rf_reset_all = 1'b0;
        done         = 1'b0;
        if (!reset) begin
            case (state)
                ST_READ_A: rf_address = ra;
                ST_READ_B: rf_address = rb;
                ST_WRITE: begin
                    rf_address = rd;
                    rf_load    = 1'b1;
                    rf_d_in    = alu[DATA_W-1:0];
                    done       = 1'b1;
                end
                ST_CLEAR: begin
                    rf_reset_all = 1'b1;
                    done         = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural 8x8 register file, table-driven instructions,
// scoreboard of expected writes, plus streaming and reset-abort sequences.
`timescale 1ns/1ps
module tb_regfile_sequencer;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, LDI = 3'b101, MOV = 3'b110, CLR = 3'b111;

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
        logic [7:0] data;
        logic       zero;
        logic       carry;
        int         lat;
    } vec_t;

    typedef struct {
        logic       clr;
        logic [2:0] addr;
        logic [7:0] data;
        logic       zero;
        logic       carry;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, req_valid, req_ready;
    logic [2:0] req_op, req_rd, req_ra, req_rb;
    logic [7:0] req_imm;
    logic [2:0] rf_address;
    logic       rf_load, rf_reset_all, done, flag_zero, flag_carry;
    logic [7:0] rf_d_in, rf_q_out, result;

    logic       clr_valid, clr_ready, clr_load, clr_reset_all, clr_done, clr_zero, clr_carry;
    logic [2:0] clr_address;
    logic [7:0] clr_d_in, clr_q, clr_result;

    logic [7:0] rf_mem [8];
    exp_t       sbq[$];
    exp_t       pend;
    bit         pend_v = 1'b0;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl [19];

    always #5 clk = ~clk;

    regfile_sequencer #(.DATA_W(8), .ADDR_W(3), .CLEAR_ON_RESET(1'b0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb), .req_imm(req_imm),
        .rf_address(rf_address), .rf_load(rf_load), .rf_d_in(rf_d_in),
        .rf_reset_all(rf_reset_all), .rf_q_out(rf_q_out), .done(done), .result(result),
        .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    regfile_sequencer #(.DATA_W(8), .ADDR_W(3), .CLEAR_ON_RESET(1'b1)) u_clr (
        .clk(clk), .reset(reset), .req_valid(clr_valid), .req_ready(clr_ready),
        .req_op(req_op), .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb), .req_imm(req_imm),
        .rf_address(clr_address), .rf_load(clr_load), .rf_d_in(clr_d_in),
        .rf_reset_all(clr_reset_all), .rf_q_out(clr_q), .done(clr_done), .result(clr_result),
        .flag_zero(clr_zero), .flag_carry(clr_carry)
    );

    // Behavioural register file: combinational read, synchronous load/clear, no reset
    always @(posedge clk) begin
        if (rf_reset_all) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
        end else if (rf_load) begin
            rf_mem[rf_address] <= rf_d_in;
        end
    end
    assign rf_q_out = rf_mem[rf_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: write/clear checked in the done cycle, result/flags one cycle later
    always @(negedge clk) begin
        exp_t e;
        if (pend_v) begin
            chk("result", 32'(result), 32'(pend.data));
            chk("flag_zero", 32'(flag_zero), 32'(pend.zero));
            chk("flag_carry", 32'(flag_carry), 32'(pend.carry));
            if (pend.clr) chk("reset_all_one_cycle", 32'(rf_reset_all), 32'd0);
            pend_v = 1'b0;
        end
        if (done) begin
            chk("done_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rf_reset_all", 32'(rf_reset_all), 32'(e.clr));
                chk("rf_load", 32'(rf_load), 32'(!e.clr));
                if (!e.clr) begin
                    chk("wr_addr", 32'(rf_address), 32'(e.addr));
                    chk("wr_data", 32'(rf_d_in), 32'(e.data));
                end
                pend   = e;
                pend_v = 1'b1;
            end
        end else if (rf_load || rf_reset_all) begin
            chk("write_has_done", 32'(done), 32'd1);
        end
    end

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.clr   = (v.op == CLR);
        e.addr  = v.rd;
        e.data  = v.data;
        e.zero  = v.zero;
        e.carry = v.carry;
        return e;
    endfunction

    task automatic drive(input vec_t v);
        req_op  = v.op;
        req_rd  = v.rd;
        req_ra  = v.ra;
        req_rb  = v.rb;
        req_imm = v.imm;
    endtask

    // Called at posedge+2; waits for ready, accepts, measures accept-to-done latency
    task automatic issue(input vec_t v);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        if (!req_ready) return;
        drive(v);
        req_valid = 1'b1;
        @(posedge clk);
        sbq.push_back(to_exp(v));
        #2;
        req_valid = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        chk("latency", 32'(n), 32'(v.lat));
    endtask

    initial begin
        vec_t s [3];
        vec_t v;
        int   i, cyc;
        bit   acc;

        tbl = '{
            '{LDI,  3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0, 1'b0, 1},
            '{LDI,  3'd2, 3'd0, 3'd0, 8'h03, 8'h03, 1'b0, 1'b0, 1},
            '{ADD,  3'd3, 3'd1, 3'd2, 8'h00, 8'h08, 1'b0, 1'b0, 3},
            '{LDI,  3'd1, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1},
            '{LDI,  3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1},
            '{ADD,  3'd4, 3'd1, 3'd2, 8'h00, 8'h00, 1'b1, 1'b1, 3},
            '{SUB,  3'd5, 3'd2, 3'd1, 8'h00, 8'h02, 1'b0, 1'b1, 3},
            '{LDI,  3'd6, 3'd0, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1},
            '{MOV,  3'd6, 3'd6, 3'd0, 8'h00, 8'hA5, 1'b0, 1'b0, 2},
            '{XOR_, 3'd6, 3'd6, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 3},
            '{LDI,  3'd4, 3'd0, 3'd0, 8'h44, 8'h44, 1'b0, 1'b0, 1},
            '{LDI,  3'd6, 3'd0, 3'd0, 8'h66, 8'h66, 1'b0, 1'b0, 1},
            '{AND_, 3'd7, 3'd1, 3'd6, 8'h00, 8'h66, 1'b0, 1'b0, 3},
            '{OR_,  3'd7, 3'd2, 3'd5, 8'h00, 8'h03, 1'b0, 1'b0, 3},
            '{CLR,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1},
            '{MOV,  3'd7, 3'd3, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 2},
            '{LDI,  3'd1, 3'd0, 3'd0, 8'h81, 8'h81, 1'b0, 1'b0, 1},
            '{ADD,  3'd1, 3'd1, 3'd1, 8'h00, 8'h02, 1'b0, 1'b1, 3},
            '{SUB,  3'd2, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 3}
        };

        reset = 1'b1; req_valid = 1'b0; clr_valid = 1'b0; clr_q = 8'h00;
        req_op = '0; req_rd = '0; req_ra = '0; req_rb = '0; req_imm = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_address", 32'(rf_address), 32'd0);
        chk("rst_load", 32'(rf_load), 32'd0);
        chk("rst_d_in", 32'(rf_d_in), 32'd0);
        chk("rst_reset_all", 32'(rf_reset_all), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(flag_zero), 32'd0);
        chk("rst_carry", 32'(flag_carry), 32'd0);
        chk("clr_rst_reset_all", 32'(clr_reset_all), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        chk("clr_pulse", 32'(clr_reset_all), 32'd1);
        chk("clr_done", 32'(clr_done), 32'd1);
        chk("clr_ready_low", 32'(clr_ready), 32'd0);
        @(posedge clk); #2;
        chk("clr_pulse_end", 32'(clr_reset_all), 32'd0);
        chk("clr_ready_high", 32'(clr_ready), 32'd1);
        chk("clr_flags", 32'({clr_result, clr_zero, clr_carry}), 32'({8'h00, 1'b1, 1'b0}));
        chk("clr_idle_bus", 32'({clr_load, clr_address, clr_d_in}), 32'd0);

        for (int k = 0; k < 19; k++) issue(tbl[k]);

        // Streaming: valid held high, three dependent ADDs
        issue('{LDI, 3'd1, 3'd0, 3'd0, 8'h10, 8'h10, 1'b0, 1'b0, 1});
        issue('{LDI, 3'd2, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0, 1'b0, 1});
        s[0] = '{ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h30, 1'b0, 1'b0, 3};
        s[1] = '{ADD, 3'd4, 3'd3, 3'd1, 8'h00, 8'h40, 1'b0, 1'b0, 3};
        s[2] = '{ADD, 3'd5, 3'd4, 3'd4, 8'h00, 8'h80, 1'b0, 1'b0, 3};
        i = 0; cyc = 0;
        drive(s[0]);
        req_valid = 1'b1;
        while (i < 3 && cyc < 60) begin
            acc = req_ready;
            @(posedge clk);
            if (acc) sbq.push_back(to_exp(s[i]));
            #2;
            cyc++;
            if (acc) begin
                i++;
                chk("ready_low_after_accept", 32'(req_ready), 32'd0);
                if (i < 3) drive(s[i]);
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("stream_accepts", 32'(i), 32'd3);
        cyc = 0;
        while ((sbq.size() != 0 || pend_v) && cyc < 40) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("stream_drain", 32'(sbq.size()), 32'd0);

        // Reset during READ_B of an ADD into r3
        issue('{LDI, 3'd3, 3'd0, 3'd0, 8'h11, 8'h11, 1'b0, 1'b0, 1});
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_abort_ready", 32'(req_ready), 32'd1);
        v = '{ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 3};
        drive(v);
        req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        chk("abort_read_a_addr", 32'(rf_address), 32'd1);
        @(posedge clk); #2;
        chk("abort_read_b_addr", 32'(rf_address), 32'd2);
        reset = 1'b1;
        #1;
        chk("abort_no_load", 32'(rf_load), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        chk("abort_rst_ready", 32'(req_ready), 32'd0);
        chk("abort_flags_cleared", 32'({result, flag_zero, flag_carry}), 32'd0);
        chk("abort_clr_quiet", 32'(clr_reset_all), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_clr_pulse", 32'(clr_reset_all), 32'd1);
        chk("abort_clr_not_ready", 32'(clr_ready), 32'd0);
        chk("abort_r3_kept", 32'(rf_mem[3]), 32'h11);
        @(posedge clk); #2;
        chk("abort_clr_ready", 32'(clr_ready), 32'd1);

        // Reset landing on the WRITE cycle must mask load/done immediately
        v = '{LDI, 3'd3, 3'd0, 3'd0, 8'h22, 8'h22, 1'b0, 1'b0, 1};
        drive(v);
        req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("wr_abort_no_load", 32'(rf_load), 32'd0);
        chk("wr_abort_no_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        chk("wr_abort_r3_kept", 32'(rf_mem[3]), 32'h11);
        issue('{ADD, 3'd4, 3'd3, 3'd3, 8'h00, 8'h22, 1'b0, 1'b0, 3});

        cyc = 0;
        while ((sbq.size() != 0 || pend_v) && cyc < 40) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("final_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle controller that sequences the single-port 8x8 register file (one address port, combinational read, synchronous load, reset_all).
- Accepts one register-to-register instruction per valid/ready handshake and issues reads of ra then rb on consecutive cycles, capturing each read value.
- Computes the ALU result and writes it back to rd, producing registered zero/carry flags.
- Sits between the instruction decoder and the register file, and is the only master of the register file's address, load, d_in and reset_all inputs.

Parameters:
- DATA_W, 8, register and ALU width.
- ADDR_W, 3, register address width (2**ADDR_W registers).
- CLEAR_ON_RESET, 0, if 1 the block performs one CLEAR cycle (reset_all pulse) immediately after reset deasserts.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high; returns the FSM to IDLE and clears flags.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  block can accept a request; equals (state==IDLE) && !reset.
- req_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LDI, 110 MOV, 111 CLRALL.
- req_rd  in  ADDR_W  destination register.
- req_ra  in  ADDR_W  source A.
- req_rb  in  ADDR_W  source B.
- req_imm  in  DATA_W  immediate for LDI.
- rf_address  out  ADDR_W  register file address.
- rf_load  out  1  register file write enable.
- rf_d_in  out  DATA_W  register file write data.
- rf_reset_all  out  1  register file clear-all.
- rf_q_out  in  DATA_W  register file combinational read data.
- done  out  1  one-cycle pulse marking instruction completion.
- result  out  DATA_W  last written value, registered.
- flag_zero  out  1  result==0, registered.
- flag_carry  out  1  ADD carry-out / SUB borrow, registered.

Behaviour:
- Reset values: state IDLE (or CLEAR if CLEAR_ON_RESET=1, entered on the first cycle after reset deasserts); rf_address=0, rf_load=0, rf_d_in=0, rf_reset_all=0, done=0, result=0, flag_zero=0, flag_carry=0.
- All rf_* outputs and done are forced to 0 while reset=1, so no write or clear escapes during reset. Register contents are not touched by reset unless CLEAR_ON_RESET=1.
- Handshake: a request is accepted on any cycle with req_valid && req_ready.
  - All req_* fields are latched on acceptance; they are don't-care afterwards.
  - req_ready is low in every non-IDLE state. No back-to-back accept: minimum 1 IDLE cycle between instructions.
- FSM states: IDLE, READ_A, READ_B, WRITE, CLEAR.
  - IDLE: rf_address=0. On accept: op ADD..XOR -> READ_A; MOV -> READ_A; LDI -> WRITE; CLRALL -> CLEAR.
  - READ_A: rf_address=ra; opa <= rf_q_out at the clock edge. Next state: READ_B for ADD..XOR, WRITE for MOV.
  - READ_B: rf_address=rb; opb <= rf_q_out. Next state: WRITE.
  - WRITE: rf_address=rd, rf_load=1, rf_d_in=alu value, done=1; result/flags update at the clock edge. Next state: IDLE.
  - CLEAR: rf_reset_all=1, done=1; result<=0, flag_zero<=1, flag_carry<=0. Next state: IDLE.
- Latency, counted from the accept edge to the WRITE/CLEAR cycle in which done is high:
  - 3 cycles for ADD..XOR.
  - 2 cycles for MOV.
  - 1 cycle for LDI and CLRALL.
- ALU, DATA_W wide, wrap-around modulo 2**DATA_W:
  - ADD: {carry,sum} = opa+opb.
  - SUB: opa-opb; carry=1 iff opa<opb (borrow).
  - AND/OR/XOR: bitwise; carry=0.
  - LDI: imm; carry=0.
  - MOV: opa; carry=0.
- Flags hold their value between instructions.
- ra==rb is legal: the register is read twice.
- rd==ra or rd==rb is legal: reads complete before the write, so the old value is used.
- Reset asserted in any state aborts the instruction in that same cycle: no rf_load, no done, and IDLE on the next edge.

Test Plan:
- LDI r1=0x05, then LDI r2=0x03 -> each has done 1 cycle after accept, rf_load=1 with rf_address 1 then 2; ADD r3=r1+r2 -> done exactly 3 cycles after accept, rf_d_in=0x08, result=0x08, zero=0, carry=0.
- LDI r1=0xFF, LDI r2=0x01, ADD r4=r1+r2 -> r4=0x00, flag_zero=1, flag_carry=1 (wrap-around); then SUB r5=r2-r1 -> 0x02, carry=1 (borrow), zero=0.
- LDI r6=0xA5, then MOV r6=r6 and XOR r6=r6^r6 -> MOV writes 0xA5 with done 2 cycles after accept; XOR reads 0xA5 on both reads, writes 0x00, zero=1.
- CLRALL with r1..r6 nonzero -> rf_reset_all high for exactly 1 cycle, done=1, flags zero=1/carry=0; a following MOV r7=r3 writes 0x00.
- Hold req_valid high continuously with 3 queued ADDs -> req_ready low during READ_A/READ_B/WRITE, each request accepted only in IDLE, no request lost or duplicated.
- Assert reset during READ_B of an ADD to r3 (r3 pre-loaded 0x11) -> no rf_load, no done, r3 stays 0x11, req_ready=1 on the first cycle after reset deasserts; with CLEAR_ON_RESET=1, one rf_reset_all pulse precedes req_ready.
